// File: rtl/wbc_vic_pkg.sv
// Shared encodings and default vectors for the vectored interrupt controller.
package wbc_vic_pkg;

  localparam int VIC_MAXN = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_ACK  = ACK,
    ST_WAIT = WAIT
  } vic_state_e;

  localparam logic [15:0] VEC_DL_RX = 16'o060;
  localparam logic [15:0] VEC_DL_TX = 16'o064;

endpackage

// File: rtl/vic_penc.sv
// Lowest-index-wins priority encoder over the interrupt requests.
module vic_penc
  import wbc_vic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [3:0]   idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    // Scan high to low so the last hit (lowest index) is the one kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = 4'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbc_vic.sv
// Vectored interrupt controller: one CPU request line, vector fetch over a
// dedicated Wishbone read select, one-cycle iack to the winning source.
module wbc_vic
  import wbc_vic_pkg::*;
#(
  parameter int            N    = 4,
  parameter logic [N*16-1:0] IVEC = {VEC_DL_TX, VEC_DL_RX, VEC_DL_TX, VEC_DL_RX},
  parameter logic [15:0]   SPUR = 16'o000000
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wb_cyc_i,
  input  logic         wb_stb_i,
  output logic         wb_ack_o,
  output logic [15:0]  wb_dat_o,
  input  logic         vic_ena_i,
  output logic         vic_irq_o,
  input  logic [N-1:0] ireq_i,
  output logic [N-1:0] iack_o
);

  vic_state_e  state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic        spur_q, spur_d;
  logic        ack_q, ack_d;
  logic        irq_q, irq_d;
  logic [15:0] dat_q, dat_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] iack_q, iack_d;

  logic [N-1:0] req_eff;
  logic [N-1:0] win_oh;
  logic [3:0]   win_idx;
  logic         win_any;
  logic [15:0]  win_vec;

  // The acknowledged source is hidden while its level is still falling.
  assign req_eff = ireq_i & ~mask_q;

  vic_penc #(.N(N)) u_penc (
    .req_i (req_eff),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    win_oh  = '0;
    win_vec = '0;
    for (int k = 0; k < N; k++) begin
      if (win_idx == 4'(k)) begin
        win_oh[k] = 1'b1;
        win_vec   = IVEC[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    spur_d  = spur_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    iack_d  = '0;
    mask_d  = '0;
    irq_d   = vic_ena_i & (|req_eff);
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_q) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (win_any) begin
            sel_d  = win_idx;
            dat_d  = win_vec;
            spur_d = 1'b0;
            iack_d = win_oh;
            mask_d = win_oh;
          end else begin
            dat_d  = SPUR;
            spur_d = 1'b1;
          end
        end
      end
      ST_ACK: begin
        // Mask stays up through the first WAIT cycle, then drops.
        state_d = ST_WAIT;
        mask_d  = mask_q;
      end
      ST_WAIT: begin
        if (!wb_stb_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      spur_q  <= 1'b0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      dat_q   <= '0;
      mask_q  <= '0;
      iack_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      spur_q  <= spur_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
      dat_q   <= dat_d;
      mask_q  <= mask_d;
      iack_q  <= iack_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign vic_irq_o = irq_q;
  assign iack_o    = iack_q;

endmodule

// File: tb/tb_wbc_vic.sv
// Directed bench for wbc_vic: stimulus queues expected fetch results and
// per-cycle checks; a negedge monitor is the single place that compares.
module tb_wbc_vic;

  localparam int K_ACK  = 0;
  localparam int K_DAT  = 1;
  localparam int K_IACK = 2;
  localparam int K_IRQ  = 3;
  localparam int K_SBE  = 4;
  localparam int K_NACK = 5;

  typedef struct {
    int          kind;
    string       nm;
    logic [15:0] exp;
  } chk_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [15:0] wb_dat_o;
  logic        vic_ena_i;
  logic        vic_irq_o;
  logic [3:0]  ireq_i;
  logic [3:0]  iack_o;

  logic [19:0] exp_q[$];
  chk_t        chk_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_cnt = 0;
  int          acks_exp = 0;

  wbc_vic #(.N(4)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_ack_o  (wb_ack_o),
    .wb_dat_o  (wb_dat_o),
    .vic_ena_i (vic_ena_i),
    .vic_irq_o (vic_irq_o),
    .ireq_i    (ireq_i),
    .iack_o    (iack_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and evaluates queued checks.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && wb_ack_o) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        cmp("sb_extra_ack", 16'd1, 16'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        cmp("sb_dat", wb_dat_o, e[19:4]);
        cmp("sb_iack", {12'd0, iack_o}, {12'd0, e[3:0]});
      end
    end else if (!wb_rst_i && iack_o != 4'd0) begin
      cmp("iack_without_ack", {12'd0, iack_o}, 16'd0);
    end
    while (chk_q.size() != 0) begin
      chk_t c;
      c = chk_q.pop_front();
      case (c.kind)
        K_ACK:   cmp(c.nm, {15'd0, wb_ack_o}, c.exp);
        K_DAT:   cmp(c.nm, wb_dat_o, c.exp);
        K_IACK:  cmp(c.nm, {12'd0, iack_o}, c.exp);
        K_IRQ:   cmp(c.nm, {15'd0, vic_irq_o}, c.exp);
        K_SBE:   cmp(c.nm, 16'(exp_q.size()), c.exp);
        default: cmp(c.nm, 16'(ack_cnt), c.exp);
      endcase
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic expect_at(input int kind, input logic [15:0] exp, input string nm);
    chk_t c;
    c.kind = kind;
    c.nm   = nm;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // Issue one vector fetch; the source model drops clr bits dly cycles after
  // the iack edge, and irq_x is the request level expected after the fetch.
  task automatic fetch(input logic [15:0] dat, input logic [3:0] iack,
                       input int hold, input logic [3:0] clr, input int dly,
                       input logic irq_x, input string tag);
    exp_q.push_back({dat, iack});
    acks_exp++;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    expect_at(K_ACK, 16'd0, {tag, "_ack_pre"});
    tick();
    expect_at(K_ACK, 16'd1, {tag, "_ack_lat"});
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == hold) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
      if (c == 1 + dly) ireq_i = ireq_i & ~clr;
      if (c == 1) expect_at(K_ACK, 16'd0, {tag, "_ack_one"});
      expect_at(K_IRQ, {15'd0, irq_x}, {tag, "_irq_after"});
    end
    expect_at(K_NACK, 16'(acks_exp), {tag, "_ack_count"});
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    wb_cyc_i  = 1'b0;
    wb_stb_i  = 1'b0;
    vic_ena_i = 1'b0;
    ireq_i    = 4'd0;
    tick();
    tick();
    expect_at(K_ACK,  16'd0, "rst_ack");
    expect_at(K_DAT,  16'd0, "rst_dat");
    expect_at(K_IACK, 16'd0, "rst_iack");
    expect_at(K_IRQ,  16'd0, "rst_irq");
    tick();
    wb_rst_i = 1'b0;

    // single source
    vic_ena_i = 1'b1;
    ireq_i    = 4'b0010;
    expect_at(K_IRQ, 16'd0, "single_irq_lat0");
    tick();
    expect_at(K_IRQ, 16'd1, "single_irq_lat1");
    fetch(16'o000064, 4'b0010, 1, 4'b0010, 0, 1'b0, "single");

    // priority between sources 2 and 3
    ireq_i = 4'b1100;
    tick();
    expect_at(K_IRQ, 16'd1, "prio_irq");
    fetch(16'o000060, 4'b0100, 1, 4'b0100, 0, 1'b1, "prio_a");
    fetch(16'o000064, 4'b1000, 1, 4'b1000, 0, 1'b0, "prio_b");

    // spurious fetch
    fetch(16'o000000, 4'b0000, 1, 4'b0000, 0, 1'b0, "spur");

    // source 0 holds its request one extra cycle past the iack
    ireq_i = 4'b0001;
    tick();
    expect_at(K_IRQ, 16'd1, "mask_irq_pre");
    fetch(16'o000060, 4'b0001, 1, 4'b0001, 1, 1'b0, "mask");

    // strobe held for 5 cycles, then a fetch to prove IDLE was re-entered
    ireq_i = 4'b0001;
    tick();
    fetch(16'o000060, 4'b0001, 5, 4'b0001, 0, 1'b0, "held");
    fetch(16'o000000, 4'b0000, 1, 4'b0000, 0, 1'b0, "held_next");

    // disabled: no irq, fetch still acknowledges the winner
    vic_ena_i = 1'b0;
    ireq_i    = 4'b0100;
    tick();
    expect_at(K_IRQ, 16'd0, "dis_irq");
    fetch(16'o000060, 4'b0100, 1, 4'b0100, 0, 1'b0, "dis");
    vic_ena_i = 1'b1;

    // all sources pending: lowest index first
    ireq_i = 4'b1111;
    tick();
    fetch(16'o000060, 4'b0001, 1, 4'b0001, 0, 1'b1, "all_0");
    fetch(16'o000064, 4'b0010, 1, 4'b0010, 0, 1'b1, "all_1");
    ireq_i = 4'd0;
    tick();
    tick();

    // reset during ACK
    ireq_i = 4'b0010;
    tick();
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick();
    wb_rst_i = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    expect_at(K_ACK,  16'd0, "rstmid_ack");
    expect_at(K_IACK, 16'd0, "rstmid_iack");
    expect_at(K_IRQ,  16'd0, "rstmid_irq");
    tick();
    wb_rst_i = 1'b0;
    expect_at(K_IRQ, 16'd0, "rstrel_irq0");
    tick();
    expect_at(K_IRQ, 16'd1, "rstrel_irq1");
    fetch(16'o000064, 4'b0010, 1, 4'b0010, 0, 1'b0, "rstrel");

    tick();
    expect_at(K_SBE, 16'd0, "sb_empty");
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
